// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA write port: wakes one drawer at a time, masks
// vga_plot until its ROM-lagged pixels are valid, and retires the grant on done or timeout.
module vga_draw_arbiter #(
    parameter int N_REQ      = 4,
    parameter int PLOT_DELAY = 2,
    parameter int FLUSH      = 1,
    parameter int TIMEOUT    = 20000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ-1:0]     drawer_done_i,
    input  logic [8*N_REQ-1:0]   drawer_x_i,
    input  logic [7*N_REQ-1:0]   drawer_y_i,
    input  logic [9*N_REQ-1:0]   drawer_colour_i,
    output logic [N_REQ-1:0]     drawer_run_o,
    output logic [7:0]           vga_x_o,
    output logic [6:0]           vga_y_o,
    output logic [8:0]           vga_colour_o,
    output logic                 vga_plot_o,
    output logic                 busy_o,
    output logic [2:0]           grant_id_o,
    output logic                 done_pulse_o,
    output logic                 timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DRAW,
        S_FLUSH,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         last_q, last_d;
    logic [14:0]        cnt_q, cnt_d;
    logic [14:0]        tcnt_q, tcnt_d;
    logic               terr_q, terr_d;
    logic [N_REQ-1:0]   run_q;
    logic [N_REQ-1:0]   grant_oh_d;
    logic               plot_q, busy_q, done_q;

    logic [2:0]         pick;
    logic [3:0]         cand;
    logic               done_sel;
    logic               tmo_hit;

    // Scan from last_q+1 upward; iterating the offsets in descending order lets the
    // nearest requester overwrite any farther one.
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, last_q} + 4'd1 + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (cand == 4'(j) && req_i[j]) begin
                    pick = cand[2:0];
                end
            end
        end
    end

    always_comb begin
        done_sel     = 1'b0;
        vga_x_o      = '0;
        vga_y_o      = '0;
        vga_colour_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q == 3'(k)) begin
                done_sel     = drawer_done_i[k];
                vga_x_o      = drawer_x_i[8*k +: 8];
                vga_y_o      = drawer_y_i[7*k +: 7];
                vga_colour_o = drawer_colour_i[9*k +: 9];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_oh
        assign grant_oh_d[gi] = (grant_d == 3'(gi));
    end

    assign tmo_hit = (tcnt_q == 15'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (tmo_hit) begin
                    terr_d  = 1'b1;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 15'd1;
                    if (cnt_q == 15'(PLOT_DELAY - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAW;
                    end else begin
                        cnt_d = cnt_q + 15'd1;
                    end
                end
            end
            S_DRAW: begin
                tcnt_d = tcnt_q + 15'd1;
                // A done arriving on the timeout cycle still counts as a clean finish.
                if (done_sel) begin
                    cnt_d   = '0;
                    state_d = (FLUSH == 0) ? S_RELEASE : S_FLUSH;
                end else if (tmo_hit) begin
                    terr_d  = 1'b1;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                tcnt_d = tcnt_q + 15'd1;
                if (cnt_q == 15'(FLUSH - 1)) begin
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            S_RELEASE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so they always match state_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= 3'(N_REQ - 1);
            cnt_q   <= '0;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
            run_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
            run_q   <= (state_d inside {S_ARM, S_DRAW, S_FLUSH}) ? grant_oh_d : '0;
            plot_q  <= (state_d == S_DRAW) || (state_d == S_FLUSH);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_RELEASE);
        end
    end

    assign drawer_run_o  = run_q;
    assign vga_plot_o    = plot_q;
    assign busy_o        = busy_q;
    assign done_pulse_o  = done_q;
    assign grant_id_o    = grant_q;
    assign timeout_err_o = terr_q;

endmodule
